// File: rtl/periph_target_adapter.sv
// Interconnect-to-backend target adapter: forwards normal requests, answers atomics with an error.
// Response two cycles after a zero-wait grant; grants stall when DEPTH outstanding or an error entry is queued.
module periph_target_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [5:0]            data_atop_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  output logic                  data_gnt_o,
  output logic                  data_r_valid_o,
  output logic [ID_WIDTH-1:0]   data_r_ID_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                  data_r_opc_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_add_o,
  output logic                  mem_wen_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_r_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_r_rdata_i
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                err;
  } entry_t;

  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  entry_t head;
  entry_t push_entry;
  logic   fifo_empty;
  logic   err_present;
  logic   is_atomic;
  logic   push;
  logic   pop;

  assign head       = fifo_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  // Error entries are only pushed into an empty FIFO, so one can only ever sit at the head.
  assign err_present = ~fifo_empty & head.err;
  assign is_atomic   = (data_atop_i != 6'd0);

  assign mem_req_o   = ~rst & data_req_i & ~is_atomic & (count_q < CNT_FULL) & ~err_present;
  assign mem_add_o   = data_add_i;
  assign mem_wen_o   = data_wen_i;
  assign mem_wdata_o = data_wdata_i;
  assign mem_be_o    = data_be_i;

  always_comb begin
    data_gnt_o = 1'b0;
    if (is_atomic) begin
      data_gnt_o = ~rst & data_req_i & fifo_empty;
    end else begin
      data_gnt_o = mem_req_o & mem_gnt_i;
    end
  end

  assign push       = data_gnt_o;
  assign push_entry = '{id: data_ID_i, err: is_atomic};
  // Backend responses with nothing (or only an error entry) outstanding are dropped.
  assign pop        = ~fifo_empty & (head.err | mem_r_valid_i);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r_valid_o <= 1'b0;
      data_r_ID_o    <= '0;
      data_r_rdata_o <= '0;
      data_r_opc_o   <= 1'b0;
    end else begin
      data_r_valid_o <= pop;
      if (pop) begin
        data_r_ID_o    <= head.id;
        data_r_rdata_o <= head.err ? '0 : mem_r_rdata_i;
        data_r_opc_o   <= head.err;
      end
    end
  end

endmodule

// File: doc/periph_target_adapter.md
PERIPH_TARGET_ADAPTER -- requirements
Module: periph_target_adapter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write/read data width.
REQ-003 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-004 SHALL have parameter ID_WIDTH, default 16, initiator ID width.
REQ-005 SHALL have parameter DEPTH, default 4 (>=2), maximum outstanding transactions.
REQ-006 Ports, in order: clk in 1 clock; rst in 1 reset (one clock; asynchronous, active-high reset).
REQ-007 data_req_i in 1; data_add_i in ADDR_WIDTH; data_wen_i in 1 (1=read, 0=write); data_atop_i in 6; data_wdata_i in DATA_WIDTH; data_be_i in BE_WIDTH; data_ID_i in ID_WIDTH (interconnect request).
REQ-008 data_gnt_o out 1, request accepted this cycle.
REQ-009 data_r_valid_o out 1; data_r_ID_o out ID_WIDTH; data_r_rdata_o out DATA_WIDTH; data_r_opc_o out 1 (1=error) (response to interconnect, no backpressure).
REQ-010 mem_req_o out 1; mem_add_o out ADDR_WIDTH; mem_wen_o out 1; mem_wdata_o out DATA_WIDTH; mem_be_o out BE_WIDTH (backend request).
REQ-011 mem_gnt_i in 1; mem_r_valid_i in 1; mem_r_rdata_i in DATA_WIDTH (backend grant and in-order response, one per granted backend request, reads and writes).

Function
REQ-012 SHALL keep an ID FIFO of DEPTH entries {ID, err}, plus an occupancy count 0..DEPTH, width $clog2(DEPTH+1).
REQ-013 Normal request (data_atop_i==0): mem_req_o = data_req_i & (count<DEPTH) & ~err_present; address/wen/wdata/be pass through combinationally; data_gnt_o = mem_req_o & mem_gnt_i.
REQ-014 On normal handshake, push {data_ID_i, err=0}.
REQ-015 Atomic request (data_atop_i!=0): never forwarded (mem_req_o=0); data_gnt_o=1 only when count==0; push {data_ID_i, err=1}.
REQ-016 err_present: while an err entry is in the FIFO, data_gnt_o=0 for all requests.
REQ-017 Pop: head err=1 -> pop in the cycle after its push; head err=0 -> pop when mem_r_valid_i=1.
REQ-018 Response registered: cycle after pop, data_r_valid_o=1 for exactly one cycle, data_r_ID_o=popped ID; err=0 -> data_r_rdata_o=mem_r_rdata_i captured, data_r_opc_o=0; err=1 -> data_r_rdata_o=0, data_r_opc_o=1.
REQ-019 data_r_rdata_o/ID/opc hold last value when data_r_valid_o=0.
REQ-020 Latency: zero-wait backend (mem_r_valid_i the cycle after handshake) -> data_r_valid_o two cycles after handshake; atomic error -> two cycles after grant.
REQ-021 Full: count==DEPTH blocks grant even if a pop occurs in the same cycle (no bypass).
REQ-022 Simultaneous push and pop: count unchanged, both entries handled correctly.
REQ-023 FIFO pointers wrap modulo DEPTH; response order equals grant order.
REQ-024 mem_r_valid_i while FIFO empty or head err=1 is a protocol violation: ignored, state unchanged.

Reset
REQ-025 rst asserted (asynchronously): count=0, pointers=0, data_r_valid_o=0, data_r_ID_o=0, data_r_rdata_o=0, data_r_opc_o=0; data_gnt_o and mem_req_o are 0 while rst=1.
REQ-026 Reset mid-operation discards outstanding entries; backend responses arriving after reset are ignored per REQ-024.

Verification
REQ-027 Read ID=0x5, addr 0x100, backend gnt same cycle, r_valid next cycle with rdata 0xCAFE0001 -> data_r_valid_o two cycles after grant, ID 0x5, rdata 0xCAFE0001, opc 0.
REQ-028 Four back-to-back reads (IDs 1..4), backend stalls responses -> fifth request not granted; after one mem_r_valid_i, fifth granted next cycle; responses in order 1..5.
REQ-029 Atomic (atop=0x21, ID 0x9) with count==0 -> granted, mem_req_o=0, response two cycles later opc=1, rdata 0, ID 0x9; a normal request in the following cycle is held off one cycle.
REQ-030 Atomic while count=2 -> data_gnt_o=0 until count returns to 0, then granted.
REQ-031 Continuous read stream at full rate, DEPTH=4, 20 transactions -> pointers wrap, no ID reordering or loss, count never exceeds 4.
REQ-032 rst pulsed with 3 outstanding -> all outputs 0, count 0; late mem_r_valid_i produces no data_r_valid_o.
